msi_bus_arbiter: RTL
====================

# msi_bus_arbiter

Two-core coherence bus controller for the MSI snooping L1 caches. Takes bus requests (invalidate, write miss, read miss) and dirty write-backs from each core's cache. Grants one transaction at a time with round-robin fairness, and runs the snoop phase to the opposite cache. Either forwards snooped data or sequences a main-memory read, and serializes write-backs to memory.

## Interface
- ADDR_W, 9, block address width ({tag, index})
- DATA_W, 32, line data width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  2  per-core bus request valid (bit n = core n)
- req_op0, req_op1  in  2 each  request opcode: INVALIDATE=00, WRITE_MISS=01, READ_MISS=10; 11 treated as INVALIDATE
- req_addr0, req_addr1  in  ADDR_W each  request block address
- wb_req  in  2  per-core write-back request valid
- wb_addr0, wb_addr1  in  ADDR_W each  write-back address
- wb_data0, wb_data1  in  DATA_W each  write-back data
- grant  out  2  one-hot owner of current request transaction
- done  out  2  one-cycle completion pulse for a request
- wb_done  out  2  one-cycle completion pulse for a write-back
- snoop_valid  out  1  snoop phase active
- snoop_op  out  2  opcode presented to the snooping cache
- snoop_addr  out  ADDR_W  address presented to the snooping cache
- snoop_abort  in  1  other cache holds valid copy; skip memory
- snoop_data  in  DATA_W  data supplied by snooping cache
- mem_rd, mem_wr  out  1 each  memory strobes, held until mem_ack
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write-back data to memory
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle
- rsp_data  out  DATA_W  fill data for the requester, valid with done
- rsp_found  out  1  rsp_data came from the other cache, valid with done

## Operation
- States: IDLE, WB, SNOOP, MEM_RD, DONE.
- IDLE, selection order:
  - Any wb_req wins over any req.
  - Among two write-backs, or among two requests, pick with a shared round-robin pointer `last`. The core not served last wins.
  - With no requests, stay in IDLE.
- WB:
  - mem_wr=1; mem_addr and mem_wdata are taken from the chosen core's wb_addr and wb_data, captured on entry.
  - On mem_ack: pulse wb_done[n], update `last`=n, go to IDLE.
- SNOOP, one cycle:
  - grant[n]=1, snoop_valid=1; snoop_op and snoop_addr are the captured request values, so the snooper is core 1-n.
  - INVALIDATE goes to DONE with rsp_found=0 and rsp_data=0.
  - READ_MISS or WRITE_MISS with snoop_abort=1 captures snoop_data and sets rsp_found=1, then goes to DONE.
  - Otherwise go to MEM_RD.
- MEM_RD:
  - mem_rd=1 and mem_addr=captured address, with grant held.
  - On mem_ack: capture mem_rdata, rsp_found=0, go to DONE.
- DONE, one cycle:
  - grant[n] stays 1, done[n]=1, rsp_data and rsp_found are valid.
  - Update `last`=n, go to IDLE.
- Requesters hold req, op and addr stable until done. Req is captured at selection; deassertion mid-transaction is ignored and the transaction completes.
- One core may hold both wb_req and req. The write-back is served first, so memory is updated before the fill.
- mem_rd and mem_wr are never high together; grant is zero outside SNOOP, MEM_RD and DONE.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - `last`=1, so core 0 is favoured first.
  - Capture registers 0.
- Reset mid-transaction: outputs drop to 0 asynchronously, the transaction is lost, and there is no done or wb_done pulse.
- All outputs are registered-state decodes; there are no combinational paths from inputs to outputs.
- Request sampled in IDLE at edge t:
  - SNOOP occupies cycle t+1.
  - With snoop_abort or INVALIDATE, done is high in cycle t+2.
  - With memory, mem_rd rises at t+2. If mem_ack arrives in cycle t+1+k (k≥1), done is high in cycle t+2+k.
- Write-back sampled at t: mem_wr rises at t+1. wb_done is high the cycle after the mem_ack cycle.
- snoop_abort and snoop_data are sampled only at the end of the SNOOP cycle; mem_ack is ignored outside WB and MEM_RD.
- Back-to-back: IDLE is always visited for one cycle between transactions, giving a minimum 3-cycle request turnaround.

## Structure
- Package msi_bus_pkg holds:
  - Bus opcodes: BUS_INVALIDATE=2'b00, BUS_WRITE_MISS=2'b01, BUS_READ_MISS=2'b10.
  - MSI line-state constants: INVALID=00, MODIFIED=01, SHARED=10.
  - The arbiter state enum.
- Sub-module rr_arbiter2: two-requester round-robin picker.
  - Inputs: request vector, `last`.
  - Output: one-hot pick.
  - Instantiated twice, once for write-backs and once for requests.

## Test plan
- After reset, core 0 issues READ_MISS addr 0x025 with snoop_abort=0; memory acks 2 cycles after mem_rd with 0xDEADBEEF. Required: mem_addr=0x025, done[0] pulses with rsp_data=0xDEADBEEF and rsp_found=0.
- Core 1 issues WRITE_MISS addr 0x103; core 0 answers snoop_abort=1 with snoop_data=0x0000ABCD. Required: snoop_addr=0x103, snoop_op=01, no mem_rd, done[1] two cycles after sampling, rsp_found=1, rsp_data=0x0000ABCD.
- Both cores hold req continuously with INVALIDATE. Required: grants alternate 0,1,0,1, each done 2 cycles after its selection, and no memory strobes.
- Core 0 raises wb_req (addr 0x011, data 0x12345678) and req READ_MISS 0x031 in the same cycle. Required: mem_wr with 0x011/0x12345678 completes and wb_done[0] pulses before any grant[0]; then the read proceeds.
- Both cores raise wb_req together after core 0 was last served. Required: core 1's write-back goes first, then core 0's.
- rst_n is asserted low during MEM_RD. Required: mem_rd and grant drop immediately, no done pulse; after release, a new request is served normally starting with core 0.

Source files
------------

// File: rtl/msi_bus_pkg.sv
// Shared types and constants for the two-core MSI coherence bus controller.
package msi_bus_pkg;

    localparam logic [1:0] BUS_INVALIDATE = 2'b00;
    localparam logic [1:0] BUS_WRITE_MISS = 2'b01;
    localparam logic [1:0] BUS_READ_MISS  = 2'b10;

    localparam logic [1:0] INVALID  = 2'b00;
    localparam logic [1:0] MODIFIED = 2'b01;
    localparam logic [1:0] SHARED   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WB     = 3'd1,
        ST_SNOOP  = 3'd2,
        ST_MEM_RD = 3'd3,
        ST_DONE   = 3'd4
    } arb_state_t;

    function automatic logic [1:0] core_onehot(input logic core);
        return core ? 2'b10 : 2'b01;
    endfunction

    // The reserved opcode 11 behaves as an invalidate.
    function automatic logic [1:0] norm_op(input logic [1:0] op);
        logic [1:0] res;
        case (op)
            BUS_WRITE_MISS: res = BUS_WRITE_MISS;
            BUS_READ_MISS:  res = BUS_READ_MISS;
            default:        res = BUS_INVALIDATE;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/msi_bus_arbiter_rr.sv
// Two-requester round-robin picker: on contention the core not served last wins.
module rr_arbiter2
    import msi_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    // One-hot pick from the request vector and the last-served core.
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = core_onehot(~last);
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/msi_bus_arbiter.sv
// Coherence bus controller: serializes write-backs and bus requests from two
// MSI caches, runs the snoop phase and sequences memory reads/writes.
module msi_bus_arbiter
    import msi_bus_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        req_op0,
    input  logic [1:0]        req_op1,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [1:0]        wb_req,
    input  logic [ADDR_W-1:0] wb_addr0,
    input  logic [ADDR_W-1:0] wb_addr1,
    input  logic [DATA_W-1:0] wb_data0,
    input  logic [DATA_W-1:0] wb_data1,
    output logic [1:0]        grant,
    output logic [1:0]        done,
    output logic [1:0]        wb_done,
    output logic              snoop_valid,
    output logic [1:0]        snoop_op,
    output logic [ADDR_W-1:0] snoop_addr,
    input  logic              snoop_abort,
    input  logic [DATA_W-1:0] snoop_data,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_found
);

    arb_state_t        state_r, state_nxt_s;
    logic              last_r, last_nxt_s;
    logic              owner_r, owner_nxt_s;
    logic [1:0]        op_r, op_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic [ADDR_W-1:0] wb_addr_r, wb_addr_nxt_s;
    logic [DATA_W-1:0] wb_data_r, wb_data_nxt_s;
    logic [DATA_W-1:0] fill_r, fill_nxt_s;
    logic              found_r, found_nxt_s;

    logic [1:0]        wb_pick_s, req_pick_s;
    logic [1:0]        grant_nxt_s, done_nxt_s, wb_done_nxt_s, snoop_op_nxt_s;
    logic              snoop_valid_nxt_s, mem_rd_nxt_s, mem_wr_nxt_s, rsp_found_nxt_s;
    logic [ADDR_W-1:0] snoop_addr_nxt_s, mem_addr_nxt_s;
    logic [DATA_W-1:0] mem_wdata_nxt_s, rsp_data_nxt_s;

    rr_arbiter2 u_wb_pick (.req(wb_req), .last(last_r), .pick(wb_pick_s));
    rr_arbiter2 u_req_pick (.req(req), .last(last_r), .pick(req_pick_s));

    // Next-state, capture and round-robin pointer update.
    always_comb begin
        state_nxt_s   = state_r;
        last_nxt_s    = last_r;
        owner_nxt_s   = owner_r;
        op_nxt_s      = op_r;
        addr_nxt_s    = addr_r;
        wb_addr_nxt_s = wb_addr_r;
        wb_data_nxt_s = wb_data_r;
        fill_nxt_s    = fill_r;
        found_nxt_s   = found_r;
        wb_done_nxt_s = 2'b00;
        case (state_r)
            ST_IDLE: begin
                // Write-backs first so memory is current before any fill.
                if (wb_req != 2'b00) begin
                    state_nxt_s   = ST_WB;
                    owner_nxt_s   = (wb_pick_s == 2'b10);
                    wb_addr_nxt_s = (wb_pick_s == 2'b10) ? wb_addr1 : wb_addr0;
                    wb_data_nxt_s = (wb_pick_s == 2'b10) ? wb_data1 : wb_data0;
                end else if (req != 2'b00) begin
                    state_nxt_s = ST_SNOOP;
                    owner_nxt_s = (req_pick_s == 2'b10);
                    op_nxt_s    = norm_op((req_pick_s == 2'b10) ? req_op1 : req_op0);
                    addr_nxt_s  = (req_pick_s == 2'b10) ? req_addr1 : req_addr0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WB: begin
                if (mem_ack) begin
                    state_nxt_s   = ST_IDLE;
                    wb_done_nxt_s = core_onehot(owner_r);
                    last_nxt_s    = owner_r;
                end else begin
                    state_nxt_s = ST_WB;
                end
            end
            ST_SNOOP: begin
                if (op_r == BUS_INVALIDATE) begin
                    state_nxt_s = ST_DONE;
                    fill_nxt_s  = {DATA_W{1'b0}};
                    found_nxt_s = 1'b0;
                end else if (snoop_abort) begin
                    state_nxt_s = ST_DONE;
                    fill_nxt_s  = snoop_data;
                    found_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_MEM_RD;
                end
            end
            ST_MEM_RD: begin
                if (mem_ack) begin
                    state_nxt_s = ST_DONE;
                    fill_nxt_s  = mem_rdata;
                    found_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_MEM_RD;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                last_nxt_s  = owner_r;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output values decoded from the next state so the outputs come straight from flops.
    always_comb begin
        grant_nxt_s       = 2'b00;
        done_nxt_s        = 2'b00;
        snoop_valid_nxt_s = 1'b0;
        snoop_op_nxt_s    = 2'b00;
        snoop_addr_nxt_s  = {ADDR_W{1'b0}};
        mem_rd_nxt_s      = 1'b0;
        mem_wr_nxt_s      = 1'b0;
        mem_addr_nxt_s    = {ADDR_W{1'b0}};
        mem_wdata_nxt_s   = {DATA_W{1'b0}};
        rsp_data_nxt_s    = {DATA_W{1'b0}};
        rsp_found_nxt_s   = 1'b0;
        case (state_nxt_s)
            ST_WB: begin
                mem_wr_nxt_s    = 1'b1;
                mem_addr_nxt_s  = wb_addr_nxt_s;
                mem_wdata_nxt_s = wb_data_nxt_s;
            end
            ST_SNOOP: begin
                grant_nxt_s       = core_onehot(owner_nxt_s);
                snoop_valid_nxt_s = 1'b1;
                snoop_op_nxt_s    = op_nxt_s;
                snoop_addr_nxt_s  = addr_nxt_s;
            end
            ST_MEM_RD: begin
                grant_nxt_s    = core_onehot(owner_nxt_s);
                mem_rd_nxt_s   = 1'b1;
                mem_addr_nxt_s = addr_nxt_s;
            end
            ST_DONE: begin
                grant_nxt_s     = core_onehot(owner_nxt_s);
                done_nxt_s      = core_onehot(owner_nxt_s);
                rsp_data_nxt_s  = fill_nxt_s;
                rsp_found_nxt_s = found_nxt_s;
            end
            default: begin
                grant_nxt_s = 2'b00;
            end
        endcase
    end

    // State, capture and output registers; reset clears everything and favours core 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            last_r      <= 1'b1;
            owner_r     <= 1'b0;
            op_r        <= 2'b00;
            addr_r      <= {ADDR_W{1'b0}};
            wb_addr_r   <= {ADDR_W{1'b0}};
            wb_data_r   <= {DATA_W{1'b0}};
            fill_r      <= {DATA_W{1'b0}};
            found_r     <= 1'b0;
            grant       <= 2'b00;
            done        <= 2'b00;
            wb_done     <= 2'b00;
            snoop_valid <= 1'b0;
            snoop_op    <= 2'b00;
            snoop_addr  <= {ADDR_W{1'b0}};
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= {ADDR_W{1'b0}};
            mem_wdata   <= {DATA_W{1'b0}};
            rsp_data    <= {DATA_W{1'b0}};
            rsp_found   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            last_r      <= last_nxt_s;
            owner_r     <= owner_nxt_s;
            op_r        <= op_nxt_s;
            addr_r      <= addr_nxt_s;
            wb_addr_r   <= wb_addr_nxt_s;
            wb_data_r   <= wb_data_nxt_s;
            fill_r      <= fill_nxt_s;
            found_r     <= found_nxt_s;
            grant       <= grant_nxt_s;
            done        <= done_nxt_s;
            wb_done     <= wb_done_nxt_s;
            snoop_valid <= snoop_valid_nxt_s;
            snoop_op    <= snoop_op_nxt_s;
            snoop_addr  <= snoop_addr_nxt_s;
            mem_rd      <= mem_rd_nxt_s;
            mem_wr      <= mem_wr_nxt_s;
            mem_addr    <= mem_addr_nxt_s;
            mem_wdata   <= mem_wdata_nxt_s;
            rsp_data    <= rsp_data_nxt_s;
            rsp_found   <= rsp_found_nxt_s;
        end
    end

endmodule
